rr_replay_trace_unpacker: RTL and testbench
===========================================

Name: rr_replay_trace_unpacker

Overview:
- Replay-side reader for the record packet stream.
- Takes 512-bit trace words fetched from host memory and splits them back into variable-width record packets, one per handshake, for the replay channel fan-out.
- Sits between the AXI read path of the trace read/write engine and the replay dispatcher.
- Exact inverse of the record packer: packets are concatenated LSB-first with no padding, and an all-zero header terminates the trace.

Parameters:
- LOGB_CHANNEL_CNT, 14, number of logged-bit channels; one presence bit each in the header.
- LOGE_CHANNEL_CNT, 25, number of logged-event bits following the presence bits.
- SHUFFLED_CHANNEL_WIDTHS, packed array [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0], payload width per channel in packet order.
- WIDTH, LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + sum of widths, maximum packet width.
- OFFSET_WIDTH, $clog2(WIDTH+1), width of length fields.
- AXI_WIDTH, 512, trace word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; clears buffer, level and done.
- in_data  in  AXI_WIDTH  trace word; bit 0 is the earliest stream bit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_data  out  WIDTH  packet: bits [LOGB-1:0] presence, then LOGE bits, then present payloads in ascending channel order; bits >= out_width are zero.
- out_width  out  OFFSET_WIDTH  packet length in bits.
- out_valid  out  1  packet valid.
- out_ready  in  1  packet consumed when out_valid && out_ready.
- done  out  1  sticky; end marker consumed.

Behaviour:
- HDR = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT.
- len(h) = HDR + sum of SHUFFLED_CHANNEL_WIDTHS[i] over set bits i of h[LOGB-1:0]. Compute combinationally from the buffer head; sum in OFFSET_WIDTH bits, no overflow by construction.
- Internal shift buffer BUF_W = WIDTH + AXI_WIDTH bits; level counter 0..BUF_W.
- Reset values (async on rst_n low, also forced by start): level=0, buffer=0, out_valid=0, out_data=0, out_width=0, done=0, in_ready=0.
  - in_ready rises the first cycle after reset release if space is available.
- in_ready = !done && (level + AXI_WIDTH <= BUF_W). It is registered: it may be conservative by one cycle but must never accept into a full buffer.
- Accept: write in_data at buffer bit position level (after any same-cycle extract shift); level += AXI_WIDTH.
- Extract condition, all required:
  - level >= HDR;
  - level >= len(head);
  - output register empty, or out_ready && out_valid this cycle;
  - !done.
- Extract actions:
  - out_data <= head masked above len;
  - out_width <= len;
  - buffer shifts right by len; level -= len.
- Simultaneous accept and extract: new level = level - len + AXI_WIDTH. The incoming word lands at (level - len).
- Latency: a packet wholly contained in words accepted by cycle t is presented with out_valid at t+1 at the earliest. Throughput is one packet per cycle while data suffices.
- End marker: header with presence bits and LOGE bits all zero.
  - Consumed (HDR bits) but never presented on out.
  - Sets done at the next edge; in_ready drops.
  - Any remaining bits in the buffer are discarded; level is forced to 0.
  - A packet already in the output register stays valid until consumed.
- out_data and out_width are held stable while out_valid && !out_ready.
- A packet may span up to three words (WIDTH > AXI_WIDTH). No extract occurs until all of its bits are buffered.
- start has priority over every same-cycle event; an in-flight output packet is dropped.

Test Plan (config: LOGB=2, LOGE=2, widths ch0=8, ch1=600; HDR=4, WIDTH=612):
- Single word: h=4'b0001, ch0 payload 0xA5, rest zero -> out_width=12, out_data=12'hA51, then done=1, in_ready=0, no second out_valid.
- Spanning: packet h=4'b0011 (len 612) across words 0–1, out_ready=1 -> out_valid exactly one cycle after word 1 is accepted, out_width=612, bits 12..611 match the payload.
- Back-to-back: three 12-bit packets plus marker in one word -> out_valid high 3 consecutive cycles, widths 12,12,12, then done.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data/out_width stable; in_ready deasserts once level > WIDTH; no loss or duplication after release.
- Reset mid-packet: assert rst_n=0 while level=512 -> out_valid=0, level=0 immediately. After release, a fresh stream decodes correctly from bit 0.
- start after done -> done=0, in_ready=1 next cycle; the new trace decodes identically to the first run.

Source files
------------

// File: rtl/rr_replay_trace_unpacker.sv
// Replay-side trace reader: splits 512-bit trace words back into the
// variable-width record packets built by the record packer (LSB-first, no padding).
module rr_replay_trace_unpacker #(
  parameter int LOGB_CHANNEL_CNT      = 14,
  parameter int LOGE_CHANNEL_CNT      = 25,
  parameter int RR_CHANNEL_WIDTH_BITS = 16,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS =
    {LOGB_CHANNEL_CNT{RR_CHANNEL_WIDTH_BITS'(32)}},
  parameter int WIDTH        = 487, // HDR + sum of SHUFFLED_CHANNEL_WIDTHS
  parameter int OFFSET_WIDTH = $clog2(WIDTH + 1),
  parameter int AXI_WIDTH    = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [AXI_WIDTH-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [OFFSET_WIDTH-1:0] out_width,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
);

  localparam int HDR   = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam int BUF_W = WIDTH + AXI_WIDTH;
  localparam int LW    = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]        buf_q, buf_d, shifted;
  logic [LW-1:0]           level_q, level_d, base, len_l;
  logic [OFFSET_WIDTH-1:0] len_c;
  logic [WIDTH-1:0]        out_mask;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [OFFSET_WIDTH-1:0] out_width_q, out_width_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;
  logic                    in_ready_q, in_ready_d;
  logic                    marker, ext, acc;

  // Packet length from the presence bits at the buffer head.
  always_comb begin
    len_c = OFFSET_WIDTH'(HDR);
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++)
      if (buf_q[i]) len_c = len_c + OFFSET_WIDTH'(SHUFFLED_CHANNEL_WIDTHS[i]);
  end

  assign len_l    = LW'(len_c);
  assign marker   = (buf_q[HDR-1:0] == '0);
  assign out_mask = ~({WIDTH{1'b1}} << len_c);
  assign ext      = !done_q && (level_q >= LW'(HDR)) && (level_q >= len_l) &&
                    (!out_valid_q || out_ready);
  assign acc      = in_valid && in_ready_q;

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_width_d = out_width_q;
    done_d      = done_q;
    shifted     = buf_q;
    base        = level_q;
    if (ext) begin
      if (marker) begin
        done_d = 1'b1;
      end else begin
        shifted     = buf_q >> len_l;
        base        = level_q - len_l;
        out_valid_d = 1'b1;
        out_data_d  = buf_q[WIDTH-1:0] & out_mask;
        out_width_d = len_c;
      end
    end
    buf_d   = shifted;
    level_d = base;
    // Incoming word lands just above whatever survives this cycle's extract.
    if (acc) begin
      buf_d   = shifted | (BUF_W'(in_data) << base);
      level_d = base + LW'(AXI_WIDTH);
    end
    if (done_d) begin
      buf_d   = '0;
      level_d = '0;
    end
    in_ready_d = !done_d &&
                 (({1'b0, level_d} + (LW+1)'(AXI_WIDTH)) <= (LW+1)'(BUF_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_width_q <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (start) begin
      buf_q       <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_width_q <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_width_q <= out_width_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_width = out_width_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rr_replay_trace_unpacker.sv
// Bench for rr_replay_trace_unpacker: traces are built as bit streams from
// packet lists, and every valid output cycle is checked against the packet list.
module tb_rr_replay_trace_unpacker;
  localparam int LOGB = 2, LOGE = 2, CWB = 16, WIDTH = 612, OW = 10, AXI = 512, HDR = 4;
  localparam logic [1:0][15:0] CW = {16'd600, 16'd8};

  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [AXI-1:0]   in_data = '0;
  logic             in_ready, out_valid, done;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    out_width;

  int vectors = 0, miscompares = 0;
  bit               sbits[$];
  logic [AXI-1:0]   words[$];
  logic [WIDTH-1:0] tr_d[$], exp_d[$];
  int               tr_w[$], exp_w[$];
  bit               rnd_ready = 0;
  int               hold = 0;

  rr_replay_trace_unpacker #(
    .LOGB_CHANNEL_CNT(LOGB), .LOGE_CHANNEL_CNT(LOGE), .RR_CHANNEL_WIDTH_BITS(CWB),
    .SHUFFLED_CHANNEL_WIDTHS(CW), .WIDTH(WIDTH), .OFFSET_WIDTH(OW), .AXI_WIDTH(AXI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_width(out_width), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // While a packet is presented it must be the oldest undelivered one.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_d.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_pkt: got width %0d expected no packet", out_width);
      end else begin
        chk("pkt_width", WIDTH'(out_width), WIDTH'(exp_w[0]));
        chk("pkt_data", out_data, exp_d[0]);
        if (out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_w.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!rnd_ready) out_ready = 1;
    else if (hold > 0) begin out_ready = 0; hold--; end
    else if ($urandom_range(0, 15) == 0) begin out_ready = 0; hold = 4; end
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [599:0] rnd600();
    logic [599:0] r;
    for (int i = 0; i < 600; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic new_trace();
    sbits.delete(); words.delete(); tr_d.delete(); tr_w.delete();
  endtask

  task automatic add_pkt(input logic [3:0] h, input logic [599:0] p1, input logic [7:0] p0);
    logic [WIDTH-1:0] pk;
    int w;
    pk = '0; pk[3:0] = h; w = HDR;
    if (h[0]) begin for (int i = 0; i < 8; i++) pk[w+i] = p0[i]; w += 8; end
    if (h[1]) begin for (int i = 0; i < 600; i++) pk[w+i] = p1[i]; w += 600; end
    for (int i = 0; i < w; i++) sbits.push_back(pk[i]);
    tr_d.push_back(pk); tr_w.push_back(w);
  endtask

  task automatic end_trace(input bit garbage);
    logic [AXI-1:0] x;
    repeat (HDR) sbits.push_back(1'b0);
    while (sbits.size() % AXI != 0) sbits.push_back(garbage ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int w = 0; w < sbits.size() / AXI; w++) begin
      for (int b = 0; b < AXI; b++) x[b] = sbits[w*AXI + b];
      words.push_back(x);
    end
  endtask

  task automatic load_exp();
    exp_d = tr_d; exp_w = tr_w;
  endtask

  task automatic drive_words(input bit gaps, input int first, input int cnt);
    bit got;
    for (int k = first; k < first + cnt && k < words.size(); k++) begin
      got = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_data = words[k]; in_valid = 1;
      for (int n = 0; n < 400 && !got; n++) begin
        @(negedge clk);
        if (done) break;
        if (in_ready) begin @(posedge clk); #1; got = 1; end
      end
      in_valid = 0;
      if (done) return;
      if (!got) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: word %0d got no in_ready expected accept", k);
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_d.size() != 0 || !done) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_done", WIDTH'(done), 1);
    chk("drain_ready", WIDTH'(in_ready), 0);
    chk("drain_left", WIDTH'(exp_d.size()), 0);
    @(negedge clk);
    chk("drain_ov", WIDTH'(out_valid), 0);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("start_done", WIDTH'(done), 0);
    chk("start_ov", WIDTH'(out_valid), 0);
    @(posedge clk); #1;
    chk("start_ready", WIDTH'(in_ready), 1);
  endtask

  initial begin
    logic [5:0] pat;
    int np;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", WIDTH'(out_valid), 0);
    chk("rst_ready", WIDTH'(in_ready), 0);
    chk("rst_done", WIDTH'(done), 0);
    chk("rst_width", WIDTH'(out_width), 0);
    chk("rst_data", out_data, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", WIDTH'(in_ready), 1);

    // Single 12-bit packet then marker.
    new_trace(); add_pkt(4'b0001, '0, 8'hA5); end_trace(0);
    chk("model_pkt", tr_d[0], 'hA51);
    chk("model_word", WIDTH'(words[0]), 'hA51);
    load_exp(); drive_words(0, 0, 1); wait_drain();

    // Full-width packet spanning two words.
    do_start();
    new_trace(); add_pkt(4'b0011, rnd600(), 8'($urandom)); end_trace(1);
    chk("model_span_w", WIDTH'(tr_w[0]), 612);
    load_exp(); drive_words(0, 0, 2);
    @(negedge clk); chk("span_lat_early", WIDTH'(out_valid), 0);
    @(negedge clk); chk("span_lat", WIDTH'(out_valid), 1);
    chk("span_width", WIDTH'(out_width), 612);
    wait_drain();

    // Three back-to-back packets in one word.
    do_start();
    new_trace(); repeat (3) add_pkt(4'b0001, '0, 8'($urandom)); end_trace(1);
    load_exp(); drive_words(0, 0, 1);
    for (int i = 0; i < 6; i++) begin @(negedge clk); pat[i] = out_valid; end
    chk("b2b_pattern", WIDTH'(pat), 6'b001110);
    chk("b2b_done", WIDTH'(done), 1);
    wait_drain();

    // Restart after done replays the same trace.
    do_start();
    load_exp(); drive_words(0, 0, words.size()); wait_drain();

    // Reset with half a packet buffered.
    do_start();
    new_trace(); add_pkt(4'b0011, rnd600(), 8'($urandom)); end_trace(1);
    load_exp(); drive_words(0, 0, 1);
    @(negedge clk); chk("mid_ov", WIDTH'(out_valid), 0);
    #2 rst_n = 0;
    #1 chk("rst_mid_ov", WIDTH'(out_valid), 0);
    chk("rst_mid_ready", WIDTH'(in_ready), 0);
    exp_d.delete(); exp_w.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    new_trace(); add_pkt(4'b0001, '0, 8'h3C); add_pkt(4'b0110, rnd600(), 8'h00); end_trace(1);
    load_exp(); drive_words(0, 0, words.size()); wait_drain();

    // Random traces with backpressure and input gaps.
    rnd_ready = 1;
    for (int t = 0; t < 6; t++) begin
      do_start();
      new_trace();
      np = $urandom_range(3, 12);
      for (int p = 0; p < np; p++)
        add_pkt(4'($urandom_range(1, 15)), rnd600(), 8'($urandom));
      end_trace(1);
      load_exp(); drive_words(1, 0, words.size()); wait_drain();
    end
    rnd_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
